// File: rtl/fir_filter_iq_mc.sv
// Multi-channel complex FIR with real coefficients and double-buffered coefficient reload.
// Latency: 3 clk from accepted beat to out_tvalid; one beat per clk.
// Backpressure: a single global enable (!out_tvalid | out_tready) stalls every stage and drives in_tready.
module fir_filter_iq_mc #(
  parameter int DATA_WIDTH = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int NUM_TAPS = 8,
  parameter int NUM_CHANS = 4,
  parameter logic [NUM_TAPS*COEFF_WIDTH-1:0] COEFFS_VEC =
    {1'b0, {(COEFF_WIDTH-1){1'b1}}, {((NUM_TAPS-1)*COEFF_WIDTH){1'b0}}},
  parameter bit RELOADABLE_COEFFS = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_tvalid,
  input  logic                  in_tlast,
  output logic                  in_tready,
  input  logic [DATA_WIDTH-1:0] in_i,
  input  logic [DATA_WIDTH-1:0] in_q,
  input  logic [COEFF_WIDTH-1:0] coeff_in,
  input  logic                  reload_tvalid,
  input  logic                  reload_tlast,
  output logic                  reload_tready,
  output logic                  out_tvalid,
  output logic                  out_tlast,
  input  logic                  out_tready,
  output logic [DATA_WIDTH-1:0] out_i,
  output logic [DATA_WIDTH-1:0] out_q,
  output logic [((NUM_CHANS > 1) ? $clog2(NUM_CHANS) : 1)-1:0] out_chan,
  output logic                  frame_err,
  output logic                  coeff_err
);

  localparam int CHW  = (NUM_CHANS > 1) ? $clog2(NUM_CHANS) : 1;
  localparam int PW   = DATA_WIDTH + COEFF_WIDTH;
  localparam int AW   = PW + $clog2(NUM_TAPS);
  localparam int TW   = $clog2(NUM_TAPS);
  localparam int IDXW = $clog2(NUM_TAPS + 1);
  localparam logic signed [AW-1:0] RND  = AW'(1) <<< (COEFF_WIDTH - 2);
  localparam logic signed [AW-1:0] SMAX = (AW'(1) <<< (DATA_WIDTH - 1)) - AW'(1);
  localparam logic signed [AW-1:0] SMIN = -(AW'(1) <<< (DATA_WIDTH - 1));
  localparam logic [CHW-1:0] LAST_CHAN = CHW'(NUM_CHANS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PEND} rl_state_t;

  logic en, accept, swap, wr_sh, err_nxt;
  rl_state_t state, state_nxt;
  logic [IDXW-1:0] idx, idx_nxt;
  logic [CHW-1:0] chan_cnt;

  logic signed [DATA_WIDTH-1:0]  hist_i [NUM_CHANS][NUM_TAPS-1];
  logic signed [DATA_WIDTH-1:0]  hist_q [NUM_CHANS][NUM_TAPS-1];
  logic signed [DATA_WIDTH-1:0]  tap_i [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0]  tap_q [NUM_TAPS];
  logic signed [COEFF_WIDTH-1:0] coef_act [NUM_TAPS];
  logic signed [COEFF_WIDTH-1:0] coef_sh  [NUM_TAPS];
  logic signed [COEFF_WIDTH-1:0] coef_use [NUM_TAPS];
  logic signed [PW-1:0] prod_i_n [NUM_TAPS];
  logic signed [PW-1:0] prod_q_n [NUM_TAPS];
  logic signed [PW-1:0] prod_i [NUM_TAPS];
  logic signed [PW-1:0] prod_q [NUM_TAPS];
  logic signed [AW-1:0] acc_i_n, acc_q_n, acc_i, acc_q;
  logic v1, v2, l1, l2;
  logic [CHW-1:0] c1, c2;

  assign en        = !out_tvalid || out_tready;
  assign in_tready = en;
  assign accept    = in_tvalid && en;

  function automatic logic [DATA_WIDTH-1:0] rnd_sat(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] s;
    s = (a + RND) >>> (COEFF_WIDTH - 1);
    if (s > SMAX) return SMAX[DATA_WIDTH-1:0];
    if (s < SMIN) return SMIN[DATA_WIDTH-1:0];
    return s[DATA_WIDTH-1:0];
  endfunction

  // Tap 0 is the incoming sample; the swapping beat already sees the shadow bank.
  always_comb begin
    tap_i[0] = in_i;
    tap_q[0] = in_q;
    for (int t = 1; t < NUM_TAPS; t++) begin
      tap_i[t] = hist_i[chan_cnt][t-1];
      tap_q[t] = hist_q[chan_cnt][t-1];
    end
    for (int t = 0; t < NUM_TAPS; t++) begin
      coef_use[t] = swap ? coef_sh[t] : coef_act[t];
      prod_i_n[t] = PW'(tap_i[t]) * PW'(coef_use[t]);
      prod_q_n[t] = PW'(tap_q[t]) * PW'(coef_use[t]);
    end
  end

  always_comb begin
    acc_i_n = '0;
    acc_q_n = '0;
    for (int t = 0; t < NUM_TAPS; t++) begin
      acc_i_n = acc_i_n + AW'(prod_i[t]);
      acc_q_n = acc_q_n + AW'(prod_q[t]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      chan_cnt   <= '0;
      frame_err  <= 1'b0;
      v1 <= 1'b0; v2 <= 1'b0; l1 <= 1'b0; l2 <= 1'b0; c1 <= '0; c2 <= '0;
      acc_i <= '0; acc_q <= '0;
      out_tvalid <= 1'b0; out_tlast <= 1'b0; out_chan <= '0; out_i <= '0; out_q <= '0;
      for (int t = 0; t < NUM_TAPS; t++) begin
        prod_i[t] <= '0;
        prod_q[t] <= '0;
      end
      for (int c = 0; c < NUM_CHANS; c++) begin
        for (int t = 0; t < NUM_TAPS-1; t++) begin
          hist_i[c][t] <= '0;
          hist_q[c][t] <= '0;
        end
      end
    end else begin
      frame_err <= 1'b0;
      if (accept) begin
        hist_i[chan_cnt][0] <= in_i;
        hist_q[chan_cnt][0] <= in_q;
        for (int t = 1; t < NUM_TAPS-1; t++) begin
          hist_i[chan_cnt][t] <= hist_i[chan_cnt][t-1];
          hist_q[chan_cnt][t] <= hist_q[chan_cnt][t-1];
        end
        chan_cnt  <= (in_tlast || chan_cnt == LAST_CHAN) ? '0 : chan_cnt + CHW'(1);
        frame_err <= in_tlast && (chan_cnt != LAST_CHAN);
      end
      if (en) begin
        v1 <= in_tvalid; l1 <= in_tlast; c1 <= chan_cnt;
        prod_i <= prod_i_n; prod_q <= prod_q_n;
        v2 <= v1; l2 <= l1; c2 <= c1;
        acc_i <= acc_i_n; acc_q <= acc_q_n;
        out_tvalid <= v2; out_tlast <= l2; out_chan <= c2;
        out_i <= rnd_sat(acc_i);
        out_q <= rnd_sat(acc_q);
      end
    end
  end

  // Reload sequencing; idx saturates at NUM_TAPS so over-long sets never alias to a legal count.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    err_nxt       = 1'b0;
    wr_sh         = 1'b0;
    swap          = 1'b0;
    reload_tready = 1'b0;
    case (state)
      S_IDLE, S_LOAD: begin
        reload_tready = RELOADABLE_COEFFS;
        if (RELOADABLE_COEFFS && reload_tvalid) begin
          wr_sh = idx < IDXW'(NUM_TAPS);
          if (reload_tlast) begin
            idx_nxt = '0;
            if (idx == IDXW'(NUM_TAPS - 1)) begin
              state_nxt = S_PEND;
            end else begin
              state_nxt = S_IDLE;
              err_nxt   = 1'b1;
            end
          end else begin
            state_nxt = S_LOAD;
            if (idx != IDXW'(NUM_TAPS)) idx_nxt = idx + IDXW'(1);
          end
        end
      end
      S_PEND: begin
        if (accept && chan_cnt == '0 && !clear) begin
          swap      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      coeff_err <= 1'b0;
      for (int t = 0; t < NUM_TAPS; t++) begin
        coef_act[t] <= COEFFS_VEC[(NUM_TAPS-1-t)*COEFF_WIDTH +: COEFF_WIDTH];
        coef_sh[t]  <= COEFFS_VEC[(NUM_TAPS-1-t)*COEFF_WIDTH +: COEFF_WIDTH];
      end
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      coeff_err <= err_nxt;
      if (wr_sh) coef_sh[idx[TW-1:0]] <= coeff_in;
      if (swap) coef_act <= coef_sh;
    end
  end

endmodule

// File: doc/fir_filter_iq_mc.md
Name: fir_filter_iq_mc

Overview:
- Multi-channel complex-input FIR with real coefficients. Processes NUM_CHANS time-interleaved IQ streams on one AXI-Stream-style port.
- Each channel keeps its own I and Q delay lines. One coefficient set is shared by all channels.
- The coefficient set is double-buffered and reloadable. A new set takes effect only on a frame boundary.
- I and Q share a single handshake, with no separate per-rail valid/ready. Sits between the DDC/resampler chain and the packetizer in the dk_hdl datapath.

Parameters:
- DATA_WIDTH, 16, width of in_i/in_q/out_i/out_q (two's complement).
- COEFF_WIDTH, 16, coefficient width, signed Q1.(COEFF_WIDTH-1).
- NUM_TAPS, 8, taps per filter, range 2..32.
- NUM_CHANS, 4, number of interleaved channels, range 1..16.
- COEFFS_VEC, {16'h7FFF, 0...}, reset coefficient set; tap 0 sits in the MS slice.
- RELOADABLE_COEFFS, 1, enables the reload port; 0 ties reload_tready low and freezes COEFFS_VEC.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- clear  in  1  synchronous flush of datapath state; coefficients are kept.
- in_tvalid  in  1  input beat valid.
- in_tlast  in  1  last beat of frame.
- in_tready  out  1  input ready.
- in_i  in  DATA_WIDTH  input I sample.
- in_q  in  DATA_WIDTH  input Q sample.
- coeff_in  in  COEFF_WIDTH  reload coefficient.
- reload_tvalid  in  1  reload beat valid.
- reload_tlast  in  1  last reload beat.
- reload_tready  out  1  reload ready.
- out_tvalid  out  1  output valid.
- out_tlast  out  1  delayed in_tlast.
- out_tready  in  1  output ready.
- out_i  out  DATA_WIDTH  filtered I.
- out_q  out  DATA_WIDTH  filtered Q.
- out_chan  out  clog2(NUM_CHANS) (min 1)  channel index of the output beat.
- frame_err  out  1  one-cycle pulse when in_tlast is accepted with chan_cnt != NUM_CHANS-1.
- coeff_err  out  1  one-cycle pulse when a reload set of the wrong length is discarded.

Behaviour:
- Reset values (reset=1): out_tvalid=0, out_tlast=0, out_i=0, out_q=0, out_chan=0, frame_err=0, coeff_err=0, reload_tready=RELOADABLE_COEFFS.
- Reset also zeroes all delay lines and pipeline stages, sets chan_cnt=0, sets the active and shadow banks to COEFFS_VEC, and clears commit_pending.
- clear: same effect as reset on the datapath (delay lines, pipeline, chan_cnt, outputs). Coefficient banks and commit_pending are untouched.
- Pipeline: 3 stages (tap select/multiply, adder tree, round/saturate).
  - Global enable en = !out_tvalid | out_tready; in_tready = en.
  - The whole pipeline stalls while en=0.
  - Latency is exactly 3 clk from the accepted beat to out_tvalid when never stalled. Throughput is 1 beat/clk.
  - out_i/out_q/out_tlast/out_chan are held stable while out_tvalid & !out_tready.
- Channel sequencing:
  - Accepted beat k belongs to channel chan_cnt, which increments by 1 per accepted beat and wraps NUM_CHANS-1 -> 0.
  - An accepted in_tlast forces chan_cnt -> 0 next.
  - If in_tlast is accepted while chan_cnt != NUM_CHANS-1, frame_err pulses; the beat is still filtered normally.
- Delay line: on accept, channel c's I/Q lines shift; tap 0 is the newest sample. Other channels' lines are unchanged.
- Arithmetic:
  - acc = sum over taps of x[n-t]*h[t], with full width DATA_WIDTH+COEFF_WIDTH+clog2(NUM_TAPS).
  - Output = (acc + 2^(COEFF_WIDTH-2)) >>> (COEFF_WIDTH-1), i.e. round half up, then saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - I and Q are computed identically and independently.
- Coefficient reload FSM, states IDLE, LOAD, PENDING:
  - IDLE/LOAD: reload_tready=1. Each accepted beat writes shadow[idx] and increments idx; the first beat is tap 0. Beats beyond NUM_TAPS are ignored but still counted.
  - An accepted reload_tlast with total count == NUM_TAPS moves to PENDING (reload_tready=0).
  - An accepted reload_tlast with any other count pulses coeff_err, resets idx to 0, and returns to IDLE; the active bank is unchanged.
  - PENDING -> IDLE: active <= shadow in the cycle an input beat with chan_cnt==0 is accepted; that beat and the rest of its frame use the new set. If no frame is in progress and chan_cnt==0, the swap happens on the next accepted beat.
  - The reload port and data port may be active in the same cycle; they do not interact.
- Reset or clear in mid-frame drops in-flight beats: no out_tvalid for them.

Test Plan:
- Impulse, default COEFFS_VEC, NUM_CHANS=4: feed ch0 I=1000, Q=-1000, other channels 0, with out_tready=1. Required: out beat 3 clk later, out_i=1000, out_q=-1000, out_chan=0; all following ch0 outputs are 0.
- Reload 8 taps all 16'h7FFF, then a constant input 32767 on all channels. Required: ch0 output at the 8th frame (all 8 taps filled) is out_i=32767 (saturated); input -32768 gives -32768.
- Reload issued mid-frame (chan_cnt=2). Required: ch2/ch3 of the current frame still use the old taps, the next ch0 uses the new taps, and reload_tready=0 until the swap.
- Reload with 7 beats + tlast. Required: coeff_err pulses once, output is unchanged vs the previous set, and reload_tready=1 the next cycle.
- Backpressure: toggle out_tready 1/0 every cycle over 64 beats. Required: no loss or duplication, outputs stay stable while stalled, and out_chan sequence is 0,1,2,3,... with out_tlast on ch3.
- in_tlast on ch1 -> frame_err pulses, and the next accepted beat is ch0. Assert clear mid-frame -> no out_tvalid for flushed beats, and the next output is computed from zeroed history.
